mul_unit: RTL
=============

# mul_unit

Iterative multicycle multiply engine for the multicycle ARM core. It executes the multiply operations the decoder selects on ALUControl: MUL (3'b101), UMULL (3'b110) and SMULL (3'b111). It accepts one operation per start pulse, stalls the main FSM while computing, and returns a 64-bit product (RdLo/RdHi) with a one-cycle done pulse. The datapath uses done and lmulFlag sequencing to write the two result registers.

## Interface
Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- start  in  1  request; sampled only in IDLE.
- ALUControl  in  3  operation select: 101 MUL, 110 UMULL, 111 SMULL; any other value is not a multiply.
- SrcA  in  WIDTH  multiplicand (Rn).
- SrcB  in  WIDTH  multiplier (Rm).
- busy  out  1  high in every state except IDLE; the FSM holds its state while busy is high.
- done  out  1  one-cycle pulse; results are valid while done is high and are held until the next accepted start.
- ResultLo  out  WIDTH  product bits [WIDTH-1:0].
- ResultHi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]; 0 for MUL.
- long  out  1  registered at accept: 1 for UMULL/SMULL, 0 for MUL; held with the results.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE to CALC: on start=1 with ALUControl in {101,110,111}.
  - Latch op and long.
  - SMULL: latch |SrcA| and |SrcB|, and neg = SrcA[31]^SrcB[31].
  - MUL/UMULL: latch the raw operands, neg = 0.
  - Clear the 2*WIDTH accumulator and set count = 0.
- start with any other ALUControl value: ignored, stays IDLE, busy stays 0.
- CALC, each cycle:
  - If mplier[0], acc += mcand, where mcand is 2*WIDTH wide and zero-extended.
  - mcand <<= 1; mplier >>= 1; count++.
  - After the 32nd CALC cycle (count reaches WIDTH), go to SIGN.
- SIGN:
  - If neg, acc = -acc (two's complement, 64-bit).
  - Register ResultLo = acc[31:0].
  - Register ResultHi = long ? acc[63:32] : 0.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Abs of 0x80000000 is 0x80000000 treated as unsigned. This is correct because the magnitude fits in WIDTH unsigned bits.
- MUL low word is identical for signed and unsigned operands, so no sign handling is applied.
- start while busy: ignored. Operand or ALUControl changes after accept have no effect.
- Reset at any point, including mid-CALC: immediate return to IDLE; busy, done, long, ResultLo and ResultHi all become 0; the in-flight result is discarded.

## Timing
- Reset values: busy=0, done=0, long=0, ResultLo=0, ResultHi=0, state IDLE.
- Start accepted at edge E0. CALC occupies edges E1..E32, SIGN occupies E33, and done is high in the cycle after E33.
- Fixed latency is 33 edges from accept to done. busy is high from after E0 through the done cycle.
- Back-to-back: a start in the done cycle is ignored. A start in the next cycle (IDLE) is accepted, so throughput is one op per 35 cycles.
- Results change only at the SIGN edge.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - CALC also exits to SIGN at the edge where the shifted multiplier becomes 0. At least one CALC cycle always executes.
  - Latency is N+1 edges, where N = max(1, index of the highest set bit of the multiplier magnitude + 1).
  - Results are identical to the fixed-latency build.
- Not defined: CALC always runs exactly WIDTH cycles, giving the fixed 33-edge latency.

## Test plan
- MUL 7*6 -> ResultLo=0x0000002A, ResultHi=0, long=0, done 33 edges after accept (fixed build).
- UMULL 0xFFFFFFFF*0xFFFFFFFF -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001, long=1.
- SMULL 0x80000000*0x00000002 -> ResultHi=0xFFFFFFFF, ResultLo=0x00000000. SMULL 0xFFFFFFFF*0xFFFFFFFF -> Hi=0, Lo=1.
- start with ALUControl=000, and a second start during CALC -> both ignored; busy stays 0 for the first; the in-flight result is unchanged and done is a single pulse.
- Assert reset at count 10 of UMULL -> next cycle: IDLE, busy=0, results 0. A fresh MUL 3*3 then gives Lo=9.
- With MUL_EARLY_EXIT_EN: UMULL 3*5 -> Lo=15, Hi=0, done after 4 edges (N=3). Multiplier 0 -> product 0, done after 2 edges.

Source files
------------

// File: rtl/mul_unit_if.sv
// Handshake and result bundle between the multicycle control/datapath and mul_unit.
// master drives requests and operands; slave (mul_unit) returns status and product words.
interface mul_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ResultLo;
  logic [WIDTH-1:0] ResultHi;
  logic             long;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  busy, done, ResultLo, ResultHi, long
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output busy, done, ResultLo, ResultHi, long
  );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier for MUL/UMULL/SMULL with a one-cycle done pulse.
// Optional MUL_EARLY_EXIT_EN: leave CALC once the remaining multiplier is zero.
module mul_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mul_unit_if.slave bus
);
  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand, acc_fin;
  logic [WIDTH-1:0]   mplier, a_mag, b_mag, res_lo, res_hi;
  logic [CW-1:0]      count;
  logic               neg, long_q, is_mul, is_smull, accept, calc_last;

  // 101, 110, 111 are the only multiply encodings
  assign is_mul   = bus.ALUControl[2] & (bus.ALUControl[1] | bus.ALUControl[0]);
  assign is_smull = (bus.ALUControl == 3'b111);
  assign accept   = (state == IDLE) && bus.start && is_mul;

  // SMULL runs unsigned on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude
  assign a_mag = (is_smull && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
  assign b_mag = (is_smull && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

`ifdef MUL_EARLY_EXIT_EN
  assign calc_last = (count == LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign calc_last = (count == LAST);
`endif

  assign acc_fin = neg ? -acc : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      neg    <= 1'b0;
      long_q <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
    end else if (accept) begin
      long_q <= (bus.ALUControl != 3'b101);
      neg    <= is_smull & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      count  <= '0;
    end else if (state == CALC) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end else if (state == SIGN) begin
      res_lo <= acc_fin[WIDTH-1:0];
      res_hi <= long_q ? acc_fin[2*WIDTH-1:WIDTH] : '0;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.ResultLo = res_lo;
  assign bus.ResultHi = res_hi;
  assign bus.long     = long_q;
endmodule
